// File: rtl/dlx_ex_stage.sv
// DLX execute stage: 32-bit ALU with combinational result/flags for ID-stage forwarding,
// followed by the EX/MEM interstage register clocked on the falling edge of clk.
module dlx_ex_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [4:0]          Op_ex,
    input  logic                MemtoReg_ex,
    input  logic                RegWrite_ex,
    input  logic                MemWrite_ex,
    input  logic [REG_BITS-1:0] towrite,
    input  logic [WIDTH-1:0]    mem_data,
    output logic [WIDTH-1:0]    Result_ex,
    output logic                Carryout,
    output logic                Overflow,
    output logic                Zero,
    output logic                Set,
    output logic [WIDTH-1:0]    Result_mem,
    output logic                MemtoReg_mem,
    output logic                RegWrite_mem,
    output logic                MemWrite_mem,
    output logic [REG_BITS-1:0] towrite_ex,
    output logic [WIDTH-1:0]    mem_data_ex
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_ADDU  = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_SUBU  = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SRA   = 5'b01001;
    localparam logic [4:0] OP_SEQ   = 5'b01010;
    localparam logic [4:0] OP_SNE   = 5'b01011;
    localparam logic [4:0] OP_SLT   = 5'b01100;
    localparam logic [4:0] OP_SGT   = 5'b01101;
    localparam logic [4:0] OP_SLE   = 5'b01110;
    localparam logic [4:0] OP_SGE   = 5'b01111;
    localparam logic [4:0] OP_LHI   = 5'b10000;
    localparam logic [4:0] OP_SLTU  = 5'b10001;
    localparam logic [4:0] OP_SGTU  = 5'b10010;
    localparam logic [4:0] OP_PASSB = 5'b10011;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic               add_ovf_s;
    logic               sub_ovf_s;
    logic               eq_s;
    logic               lt_s;
    logic               ltu_s;
    logic [4:0]         shamt_s;
    logic [WIDTH-1:0]   result_s;
    logic               carry_s;
    logic               ovf_s;
    logic               set_s;

    logic [WIDTH-1:0]    result_r;
    logic                memtoreg_r;
    logic                regwrite_r;
    logic                memwrite_r;
    logic [REG_BITS-1:0] towrite_r;
    logic [WIDTH-1:0]    mem_data_r;

    // Shared adder/subtractor and comparison terms; diff carry of 1 means no borrow.
    always_comb begin
        sum_s     = {1'b0, A} + {1'b0, B};
        diff_s    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
        sub_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
        eq_s      = (A == B);
        lt_s      = ($signed(A) < $signed(B));
        ltu_s     = (A < B);
        shamt_s   = B[4:0];
    end

    // ALU operation decode; unknown codes fall through to an all-zero result and flags.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        set_s    = 1'b0;
        case (Op_ex)
            OP_ADD: begin
                result_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = add_ovf_s;
            end
            OP_ADDU: begin
                result_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
            end
            OP_SUB: begin
                result_s = diff_s[WIDTH-1:0];
                carry_s  = diff_s[WIDTH];
                ovf_s    = sub_ovf_s;
            end
            OP_SUBU: begin
                result_s = diff_s[WIDTH-1:0];
                carry_s  = diff_s[WIDTH];
            end
            OP_AND:   result_s = A & B;
            OP_OR:    result_s = A | B;
            OP_XOR:   result_s = A ^ B;
            OP_SLL:   result_s = A << shamt_s;
            OP_SRL:   result_s = A >> shamt_s;
            OP_SRA:   result_s = $unsigned($signed(A) >>> shamt_s);
            OP_SEQ:   set_s = eq_s;
            OP_SNE:   set_s = !eq_s;
            OP_SLT:   set_s = lt_s;
            OP_SGT:   set_s = !lt_s && !eq_s;
            OP_SLE:   set_s = lt_s || eq_s;
            OP_SGE:   set_s = !lt_s;
            OP_LHI:   result_s = {B[15:0], 16'h0000};
            OP_SLTU:  set_s = ltu_s;
            OP_SGTU:  set_s = !ltu_s && !eq_s;
            OP_PASSB: result_s = B;
            default: begin
                result_s = {WIDTH{1'b0}};
                set_s    = 1'b0;
            end
        endcase
        if (set_s) begin
            result_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result_s = result_s;
        end
    end

    assign Result_ex = result_s;
    assign Carryout  = carry_s;
    assign Overflow  = ovf_s;
    assign Set       = set_s;
    assign Zero      = (result_s == {WIDTH{1'b0}});

    // EX/MEM register on the falling edge; reset injects a bubble, r0 writes are suppressed.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            result_r   <= {WIDTH{1'b0}};
            memtoreg_r <= 1'b0;
            regwrite_r <= 1'b0;
            memwrite_r <= 1'b0;
            towrite_r  <= {REG_BITS{1'b0}};
            mem_data_r <= {WIDTH{1'b0}};
        end else begin
            result_r   <= result_s;
            memtoreg_r <= MemtoReg_ex;
            regwrite_r <= RegWrite_ex && (towrite != {REG_BITS{1'b0}});
            memwrite_r <= MemWrite_ex;
            towrite_r  <= towrite;
            mem_data_r <= mem_data;
        end
    end

    assign Result_mem   = result_r;
    assign MemtoReg_mem = memtoreg_r;
    assign RegWrite_mem = regwrite_r;
    assign MemWrite_mem = memwrite_r;
    assign towrite_ex   = towrite_r;
    assign mem_data_ex  = mem_data_r;

endmodule

// File: tb/tb_dlx_ex_stage.sv
// Directed bench for dlx_ex_stage: ALU vectors with hand-computed results, then EX/MEM pipe checks.
module tb_dlx_ex_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Op_ex;
    logic        MemtoReg_ex;
    logic        RegWrite_ex;
    logic        MemWrite_ex;
    logic [4:0]  towrite;
    logic [31:0] mem_data;
    logic [31:0] Result_ex;
    logic        Carryout;
    logic        Overflow;
    logic        Zero;
    logic        Set;
    logic [31:0] Result_mem;
    logic        MemtoReg_mem;
    logic        RegWrite_mem;
    logic        MemWrite_mem;
    logic [4:0]  towrite_ex;
    logic [31:0] mem_data_ex;

    int n_cmp;
    int n_err;

    dlx_ex_stage #(.WIDTH(32), .REG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op_ex(Op_ex),
        .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex), .MemWrite_ex(MemWrite_ex),
        .towrite(towrite), .mem_data(mem_data),
        .Result_ex(Result_ex), .Carryout(Carryout), .Overflow(Overflow), .Zero(Zero), .Set(Set),
        .Result_mem(Result_mem), .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
        .MemWrite_mem(MemWrite_mem), .towrite_ex(towrite_ex), .mem_data_ex(mem_data_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_res, input logic e_c,
                       input logic e_o, input logic e_z, input logic e_s);
        Op_ex = op;
        A     = a;
        B     = b;
        #2;
        check({tag, ".res"}, Result_ex, e_res);
        check({tag, ".carry"}, {31'd0, Carryout}, {31'd0, e_c});
        check({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, e_o});
        check({tag, ".zero"}, {31'd0, Zero}, {31'd0, e_z});
        check({tag, ".set"}, {31'd0, Set}, {31'd0, e_s});
    endtask

    task automatic pipe(input string tag, input logic [31:0] e_res, input logic e_m2r,
                        input logic e_rw, input logic e_mw, input logic [4:0] e_tw,
                        input logic [31:0] e_md);
        check({tag, ".Result_mem"}, Result_mem, e_res);
        check({tag, ".MemtoReg_mem"}, {31'd0, MemtoReg_mem}, {31'd0, e_m2r});
        check({tag, ".RegWrite_mem"}, {31'd0, RegWrite_mem}, {31'd0, e_rw});
        check({tag, ".MemWrite_mem"}, {31'd0, MemWrite_mem}, {31'd0, e_mw});
        check({tag, ".towrite_ex"}, {27'd0, towrite_ex}, {27'd0, e_tw});
        check({tag, ".mem_data_ex"}, mem_data_ex, e_md);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        A = 32'd7; B = 32'd9; Op_ex = 5'b00000;
        MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; MemWrite_ex = 1'b1;
        towrite = 5'd4; mem_data = 32'h1111_2222;

        repeat (2) @(negedge clk);
        #1;
        pipe("reset", 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Control bits idle so the register contents during ALU vectors are harmless.
        @(posedge clk);
        rst_n = 1'b1;
        MemtoReg_ex = 1'b0; RegWrite_ex = 1'b0; MemWrite_ex = 1'b0;
        towrite = 5'd0; mem_data = 32'd0;

        alu("add_ovf",  5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        alu("sub_eq",   5'b00010, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        alu("subu_brw", 5'b00011, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("sub_ovf",  5'b00010, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        alu("addu_wrap",5'b00001, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        alu("slt",      5'b01100, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu("sltu",     5'b10001, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        alu("sgtu",     5'b10010, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu("sgt",      5'b01101, 32'd1,         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu("sle",      5'b01110, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        alu("sge_eq",   5'b01111, 32'd3,         32'd3,         32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu("seq",      5'b01010, 32'd4,         32'd5,         32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        alu("sne",      5'b01011, 32'd4,         32'd5,         32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu("and",      5'b00100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("or",       5'b00101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("xor",      5'b00110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("sll31",    5'b00111, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("sll_mod",  5'b00111, 32'd1,         32'd33,        32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("srl",      5'b01000, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("sra",      5'b01001, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("lhi",      5'b10000, 32'h0000_0000, 32'hFFFF_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("passb",    5'b10011, 32'h1234_5678, 32'h0000_DEAD, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0, 1'b0);
        alu("undef",    5'b11111, 32'd5,         32'd7,         32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // ADD 2+3 with writeback to r3 appears in MEM after one falling edge.
        @(posedge clk);
        Op_ex = 5'b00000; A = 32'd2; B = 32'd3;
        MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; MemWrite_ex = 1'b0;
        towrite = 5'd3; mem_data = 32'd9;
        @(negedge clk);
        #1;
        pipe("pipe_r3", 32'd5, 1'b1, 1'b1, 1'b0, 5'd3, 32'd9);

        @(posedge clk);
        towrite = 5'd0;
        @(negedge clk);
        #1;
        pipe("pipe_r0", 32'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'd9);

        // Reset held across a falling edge discards a store in flight.
        @(posedge clk);
        rst_n = 1'b0;
        MemWrite_ex = 1'b1; towrite = 5'd7; mem_data = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        pipe("rst_mid", 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        pipe("resume", 32'd5, 1'b1, 1'b1, 1'b1, 5'd7, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
